// File: rtl/mem_load_unit.sv
// MEM stage: ALU results pass through in one cycle; loads issue one word read on a req/gnt/rvalid bus and stall until data returns.
// Optional bus-timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_load_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] result_i,
  input  logic [4:0]      rd_i,
  input  logic            wb_en_i,
  input  logic            read_en_i,
  output logic            stall_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            wb_en_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            err_o
);

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT)) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_nxt;
  logic [4:0]      ld_rd;
  logic            ld_wb_en;
  logic            done;
  logic            abort;
  logic            req_nxt;
  logic [XLEN-1:0] addr_nxt;
  logic            wb_en_nxt;
  logic [4:0]      rd_nxt;
  logic [XLEN-1:0] data_nxt;

  // A response counts in REQ only when it arrives together with the grant.
  assign done = mem_rvalid_i && ((state == WAIT) || ((state == REQ) && mem_gnt_i));

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  assign abort = (state != IDLE) && (cnt == CNT_W'(TIMEOUT)) && !done;

  always_ff @(posedge clk) begin
    if (!rst_n) err_o <= 1'b0;
    else        err_o <= abort;
  end
`else
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (read_en_i) state_nxt = REQ;
      REQ:     if (done || abort) state_nxt = IDLE;
               else if (mem_gnt_i) state_nxt = WAIT;
      WAIT:    if (done || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall_o   = 1'b0;
    req_nxt   = mem_req_o;
    addr_nxt  = mem_addr_o;
    wb_en_nxt = 1'b0;
    rd_nxt    = rd_o;
    data_nxt  = wb_data_o;
    if (state == IDLE) begin
      if (read_en_i) begin
        stall_o  = 1'b1;
        req_nxt  = 1'b1;
        addr_nxt = {result_i[XLEN-1:2], 2'b00};
      end else begin
        data_nxt  = result_i;
        rd_nxt    = rd_i;
        wb_en_nxt = wb_en_i && (rd_i != 5'd0);
      end
    end else if (done) begin
      req_nxt   = 1'b0;
      data_nxt  = mem_rdata_i;
      rd_nxt    = ld_rd;
      wb_en_nxt = ld_wb_en && (ld_rd != 5'd0);
    end else if (abort) begin
      req_nxt = 1'b0;
    end else begin
      stall_o = 1'b1;
      if (state == REQ && mem_gnt_i) req_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      wb_en_o    <= 1'b0;
      rd_o       <= '0;
      wb_data_o  <= '0;
      ld_rd      <= '0;
      ld_wb_en   <= 1'b0;
    end else begin
      mem_req_o  <= req_nxt;
      mem_addr_o <= addr_nxt;
      wb_en_o    <= wb_en_nxt;
      rd_o       <= rd_nxt;
      wb_data_o  <= data_nxt;
      if (state == IDLE && read_en_i) begin
        ld_rd    <= rd_i;
        ld_wb_en <= wb_en_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: transaction-level model checked every cycle plus literal spot checks.
// Defining MEM_TIMEOUT_EN also runs the bus-timeout scenario with TIMEOUT=8.
module tb_mem_load_unit;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] result_i = '0;
  logic [4:0]  rd_i = '0;
  logic        wb_en_i = 1'b0;
  logic        read_en_i = 1'b0;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_o, mem_req_o, wb_en_o, err_o;
  logic [31:0] mem_addr_o, wb_data_o;
  logic [4:0]  rd_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_load_unit #(.XLEN(32), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .result_i(result_i), .rd_i(rd_i), .wb_en_i(wb_en_i),
    .read_en_i(read_en_i), .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_en_o(wb_en_o), .rd_o(rd_o), .wb_data_o(wb_data_o), .err_o(err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Model: one outstanding load record, plus the values WB must see next.
  bit          armed = 0;
  bit          busy = 0;
  bit          granted = 0;
  logic [4:0]  l_rd = '0;
  bit          l_wb = 0;
  int unsigned cyc = 0;
  bit          e_req = 0, e_wb = 0, e_err = 0;
  logic [31:0] e_addr = '0, e_data = '0;
  logic [4:0]  e_rd = '0;

  function automatic bit m_done();
    return busy && (granted || mem_gnt_i) && mem_rvalid_i;
  endfunction

  function automatic bit m_abort();
`ifdef MEM_TIMEOUT_EN
    return busy && (cyc == TO) && !m_done();
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_stall();
    if (!busy) return read_en_i;
    return !m_done() && !m_abort();
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      armed <= 1; busy <= 0; granted <= 0; cyc <= 0;
      e_req <= 0; e_wb <= 0; e_err <= 0; e_addr <= '0; e_data <= '0; e_rd <= '0;
    end else if (!busy) begin
      e_err <= 0;
      if (read_en_i) begin
        busy <= 1; granted <= 0; cyc <= 0; l_rd <= rd_i; l_wb <= wb_en_i;
        e_req <= 1; e_addr <= result_i & 32'hFFFF_FFFC; e_wb <= 0;
      end else begin
        e_data <= result_i; e_rd <= rd_i; e_wb <= wb_en_i && (rd_i != 0);
      end
    end else if (m_done()) begin
      busy <= 0; e_req <= 0; e_err <= 0;
      e_data <= mem_rdata_i; e_rd <= l_rd; e_wb <= l_wb && (l_rd != 0);
    end else if (m_abort()) begin
      busy <= 0; e_req <= 0; e_wb <= 0; e_err <= 1;
    end else begin
      e_wb <= 0; e_err <= 0; cyc <= cyc + 1;
      if (!granted && mem_gnt_i) begin granted <= 1; e_req <= 0; end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      if (rst_n) chk("stall", 32'(stall_o), 32'(m_stall()));
      chk("wb_en", 32'(wb_en_o), 32'(e_wb));
      chk("err", 32'(err_o), 32'(e_err));
      chk("req", 32'(mem_req_o), 32'(e_req));
      if (e_req) chk("addr", mem_addr_o, e_addr);
      if (e_wb) begin
        chk("rd", 32'(rd_o), 32'(e_rd));
        chk("data", wb_data_o, e_data);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pass(input logic [31:0] r, input logic [4:0] d, input logic w);
    result_i = r; rd_i = d; wb_en_i = w; read_en_i = 1'b0;
    step();
  endtask

  // gd: REQ cycles before gnt; rvd: cycles from gnt to rvalid (0 = same cycle).
  task automatic do_load(input logic [31:0] a, input logic [4:0] d, input logic w,
                         input int gd, input int rvd, input logic [31:0] data);
    result_i = a; rd_i = d; wb_en_i = w; read_en_i = 1'b1;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    step();
    repeat (gd) step();
    mem_gnt_i = 1'b1;
    if (rvd == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = data; end
    step();
    mem_gnt_i = 1'b0;
    if (rvd > 0) begin
      repeat (rvd - 1) step();
      mem_rvalid_i = 1'b1; mem_rdata_i = data;
      step();
    end
    mem_rvalid_i = 1'b0; read_en_i = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_wb_en", 32'(wb_en_o), 32'd0);
    chk("rst_data", wb_data_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    rst_n = 1'b1;

    // 1: pass-through
    pass(32'h1234_5678, 5'd5, 1'b1);
    chk("t1_data", wb_data_o, 32'h1234_5678);
    chk("t1_rd", 32'(rd_o), 32'd5);
    chk("t1_wb_en", 32'(wb_en_o), 32'd1);
    pass(32'h0000_00FF, 5'd0, 1'b1);
    chk("x0_wb_en", 32'(wb_en_o), 32'd0);

    // 2: load, gnt with req, rvalid 3 cycles later
    result_i = 32'h0000_1007; rd_i = 5'd3; wb_en_i = 1'b1; read_en_i = 1'b1;
    @(negedge clk); chk("t2_stall", 32'(stall_o), 32'd1);
    step();
    chk("t2_addr", mem_addr_o, 32'h0000_1004);
    chk("t2_req", 32'(mem_req_o), 32'd1);
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    step(); step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk); chk("t2_stall_done", 32'(stall_o), 32'd0);
    step(); mem_rvalid_i = 1'b0; read_en_i = 1'b0;
    chk("t2_data", wb_data_o, 32'hDEAD_BEEF);
    chk("t2_rd", 32'(rd_o), 32'd3);
    chk("t2_wb_en", 32'(wb_en_o), 32'd1);

    // 3: gnt delayed 4 cycles
    do_load(32'h0000_2002, 5'd12, 1'b1, 4, 2, 32'h0BAD_F00D);
    chk("t3_data", wb_data_o, 32'h0BAD_F00D);

    // 4: gnt and rvalid together
    do_load(32'hA5A0_0003, 5'd4, 1'b1, 1, 0, 32'hA5A5_A5A5);
    chk("t4_data", wb_data_o, 32'hA5A5_A5A5);
    chk("t4_wb_en", 32'(wb_en_o), 32'd1);
    pass(32'h0000_0042, 5'd6, 1'b1);
    chk("t4_idle", wb_data_o, 32'h0000_0042);

    // Stray bus activity: rvalid/gnt in IDLE, rvalid in REQ without gnt, load to x0
    mem_rvalid_i = 1'b1; mem_gnt_i = 1'b1; mem_rdata_i = 32'hFFFF_0000;
    pass(32'h0000_0077, 5'd7, 1'b1);
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
    chk("stray_data", wb_data_o, 32'h0000_0077);
    result_i = 32'h0000_3000; rd_i = 5'd9; wb_en_i = 1'b1; read_en_i = 1'b1;
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_1111; step();
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2222_2222; step();
    mem_rvalid_i = 1'b0; read_en_i = 1'b0;
    chk("req_rvalid_data", wb_data_o, 32'h2222_2222);
    do_load(32'h0000_4000, 5'd0, 1'b1, 0, 1, 32'h3333_3333);
    chk("ld_x0_wb_en", 32'(wb_en_o), 32'd0);
    do_load(32'h0000_4004, 5'd31, 1'b0, 0, 1, 32'h4444_4444);
    chk("ld_nowb_wb_en", 32'(wb_en_o), 32'd0);

    // 5: reset while waiting, then late rvalid
    result_i = 32'h0000_5000; rd_i = 5'd8; wb_en_i = 1'b1; read_en_i = 1'b1;
    step();
    mem_gnt_i = 1'b1; step(); mem_gnt_i = 1'b0;
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("t5_req", 32'(mem_req_o), 32'd0);
    chk("t5_wb_en_rst", 32'(wb_en_o), 32'd0);
    read_en_i = 1'b0; wb_en_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    @(negedge clk); chk("t5_stall", 32'(stall_o), 32'd0);
    step(); mem_rvalid_i = 1'b0;
    chk("t5_wb_en", 32'(wb_en_o), 32'd0);
    chk("t5_req2", 32'(mem_req_o), 32'd0);

`ifdef MEM_TIMEOUT_EN
    // 6: gnt never arrives
    begin
      int pulses;
      int wait_cyc;
      pulses = 0; wait_cyc = 0;
      result_i = 32'h0000_6000; rd_i = 5'd2; wb_en_i = 1'b1; read_en_i = 1'b1;
      step();
      while (wait_cyc < 20) begin
        if (!stall_o) read_en_i = 1'b0;
        step();
        if (err_o) pulses++;
        wait_cyc++;
      end
      chk("t6_pulses", 32'(pulses), 32'd1);
      chk("t6_req", 32'(mem_req_o), 32'd0);
    end
`endif

    pass(32'h0000_0099, 5'd1, 1'b1);
    chk("final_data", wb_data_o, 32'h0000_0099);
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
